// File: rtl/instruction_fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage and the pipeline registers
// behind it.
//   NOP_INSTRUCTION    - all-zero word loaded into a pipeline register on a bubble
//   OPCODE_* / JUMP_*  - bit positions of the opcode and J-type index fields
//   DEFAULT_RESET_PC   - PC value loaded by reset unless overridden
//   ifIdEntry_t        - IF/ID register contents {instruction, pcPlusFour, valid}
package instruction_fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTRUCTION  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int OPCODE_MSB     = 31;
    localparam int OPCODE_LSB     = 26;
    localparam int JUMP_INDEX_MSB = 25;
    localparam int JUMP_INDEX_LSB = 0;

    // pcPlusFour is always carried at the full 32-bit architectural width.
    // A narrower fetch address is zero-extended into it.
    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pcPlusFour;
        logic        valid;
    } ifIdEntry_t;

    localparam ifIdEntry_t IF_ID_BUBBLE = '{
        instruction: NOP_INSTRUCTION,
        pcPlusFour:  32'h0000_0000,
        valid:       1'b0
    };

endpackage

// File: rtl/instruction_fetch_stage_if_id_register.sv
// IF/ID pipeline register with load / hold / flush controls. The same shape
// is intended to serve as the template for the ID/EX register.
// Ports:
//   clockMachine  - rising-edge clock
//   resetMachine  - synchronous active-high reset, loads a bubble
//   flushEntry    - load a bubble (wins over loadEntry)
//   loadEntry     - capture entryNext; when low and not flushing, hold
//   entryNext     - value captured on load
//   entryCurrent  - registered contents
module if_id_register
    import instruction_fetch_stage_pkg::*;
(
    input  logic       clockMachine,
    input  logic       resetMachine,
    input  logic       flushEntry,
    input  logic       loadEntry,
    input  ifIdEntry_t entryNext,
    output ifIdEntry_t entryCurrent
);

    always_ff @(posedge clockMachine) begin
        if (resetMachine) begin
            entryCurrent <= IF_ID_BUBBLE;
        end else if (flushEntry) begin
            entryCurrent <= IF_ID_BUBBLE;
        end else if (loadEntry) begin
            entryCurrent <= entryNext;
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage of the five-stage MIPS pipeline. Holds the PC, drives the
// instruction-memory address and fills the IF/ID register. Branch and jump
// redirects each produce one bubble and bump a saturating flush counter.
// Ports:
//   clockMachine, resetMachine       - clock, synchronous active-high reset
//   stallFetch                       - hold PC, IF/ID and flushCount
//   branchTaken, branchTarget        - resolved EX-stage branch (highest priority)
//   jumpTaken                        - jump enable for the instruction in IF/ID
//   instructionAddress               - memory read address (= PC)
//   instructionData                  - combinational read data
//   instructionDecode, opCodeDecode  - IF/ID instruction and its opcode field
//   pcPlusFourDecode, validDecode    - IF/ID PC+4 and valid (0 = bubble)
//   flushCount                       - saturating count of discarded fetches
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter int                    ADDR_WIDTH        = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC          = ADDR_WIDTH'(DEFAULT_RESET_PC),
    parameter int                    FLUSH_COUNT_WIDTH = 16
) (
    input  logic                         clockMachine,
    input  logic                         resetMachine,
    input  logic                         stallFetch,
    input  logic                         branchTaken,
    input  logic [ADDR_WIDTH-1:0]        branchTarget,
    input  logic                         jumpTaken,
    output logic [ADDR_WIDTH-1:0]        instructionAddress,
    input  logic [31:0]                  instructionData,
    output logic [31:0]                  instructionDecode,
    output logic [5:0]                   opCodeDecode,
    output logic [ADDR_WIDTH-1:0]        pcPlusFourDecode,
    output logic                         validDecode,
    output logic [FLUSH_COUNT_WIDTH-1:0] flushCount
);

    localparam logic [FLUSH_COUNT_WIDTH-1:0] FLUSH_COUNT_MAX = '1;

    logic [ADDR_WIDTH-1:0] pcCurrent;
    logic [ADDR_WIDTH-1:0] pcNext;
    logic [ADDR_WIDTH-1:0] pcPlusFour;
    logic [31:0]           jumpTarget;
    logic                  jumpAccepted;
    logic                  redirectTaken;
    ifIdEntry_t            ifIdCurrent;
    ifIdEntry_t            ifIdNext;

    assign pcPlusFour = pcCurrent + ADDR_WIDTH'(4);

    // A stalled jump is simply not accepted yet; the jump stays in IF/ID
    // and redirects on the first unstalled cycle. A branch is older than
    // the jump in IF/ID, so it overrides both the stall and the jump.
    assign jumpAccepted  = jumpTaken && !stallFetch && !branchTaken;
    assign redirectTaken = branchTaken || jumpAccepted;

    assign jumpTarget = {ifIdCurrent.pcPlusFour[31:28],
                         ifIdCurrent.instruction[JUMP_INDEX_MSB:JUMP_INDEX_LSB],
                         2'b00};

    always_comb begin
        pcNext = pcPlusFour;
        if (branchTaken) begin
            pcNext = {branchTarget[ADDR_WIDTH-1:2], 2'b00};
        end else if (jumpAccepted) begin
            pcNext = jumpTarget[ADDR_WIDTH-1:0];
        end else if (stallFetch) begin
            pcNext = pcCurrent;
        end
    end

    always_ff @(posedge clockMachine) begin
        if (resetMachine) begin
            pcCurrent <= {RESET_PC[ADDR_WIDTH-1:2], 2'b00};
        end else begin
            pcCurrent <= pcNext;
        end
    end

    always_ff @(posedge clockMachine) begin
        if (resetMachine) begin
            flushCount <= '0;
        end else if (redirectTaken && (flushCount != FLUSH_COUNT_MAX)) begin
            flushCount <= flushCount + FLUSH_COUNT_WIDTH'(1);
        end
    end

    always_comb begin
        ifIdNext             = IF_ID_BUBBLE;
        ifIdNext.instruction = instructionData;
        ifIdNext.pcPlusFour  = 32'(pcPlusFour);
        ifIdNext.valid       = 1'b1;
    end

    if_id_register ifIdRegister (
        .clockMachine (clockMachine),
        .resetMachine (resetMachine),
        .flushEntry   (redirectTaken),
        .loadEntry    (!stallFetch),
        .entryNext    (ifIdNext),
        .entryCurrent (ifIdCurrent)
    );

    assign instructionAddress = pcCurrent;
    assign instructionDecode  = ifIdCurrent.instruction;
    assign opCodeDecode       = ifIdCurrent.instruction[OPCODE_MSB:OPCODE_LSB];
    assign pcPlusFourDecode   = ifIdCurrent.pcPlusFour[ADDR_WIDTH-1:0];
    assign validDecode        = ifIdCurrent.valid;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
module tb_instruction_fetch_stage;

    localparam logic [31:0] ADDI_WORD = {6'b001000, 26'h0};
    localparam logic [31:0] JUMP_WORD = {6'b000010, 26'h0000040};

    logic        clockMachine;
    logic        resetMachine;
    logic        stallFetch;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        jumpTaken;
    logic [31:0] instructionAddress;
    logic [31:0] instructionData;
    logic [31:0] instructionDecode;
    logic [5:0]  opCodeDecode;
    logic [31:0] pcPlusFourDecode;
    logic        validDecode;
    logic [15:0] flushCount;

    int checks;
    int failures;

    instruction_fetch_stage dut (
        .clockMachine       (clockMachine),
        .resetMachine       (resetMachine),
        .stallFetch         (stallFetch),
        .branchTaken        (branchTaken),
        .branchTarget       (branchTarget),
        .jumpTaken          (jumpTaken),
        .instructionAddress (instructionAddress),
        .instructionData    (instructionData),
        .instructionDecode  (instructionDecode),
        .opCodeDecode       (opCodeDecode),
        .pcPlusFourDecode   (pcPlusFourDecode),
        .validDecode        (validDecode),
        .flushCount         (flushCount)
    );

    initial clockMachine = 1'b0;
    always #5 clockMachine = ~clockMachine;

    task automatic stepCycle();
        @(posedge clockMachine);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkState(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                              input logic [31:0] pc4, input logic valid, input logic [15:0] flushes);
        check({tag, ".pc"},    instructionAddress, pc);
        check({tag, ".instr"}, instructionDecode,  instr);
        check({tag, ".pc4"},   pcPlusFourDecode,   pc4);
        check({tag, ".valid"}, 32'(validDecode),   32'(valid));
        check({tag, ".flush"}, 32'(flushCount),    32'(flushes));
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        resetMachine    = 1'b1;
        stallFetch      = 1'b0;
        branchTaken     = 1'b0;
        branchTarget    = 32'h0;
        jumpTaken       = 1'b0;
        instructionData = ADDI_WORD;

        // Reset state
        stepCycle();
        stepCycle();
        checkState("reset", 32'h0, 32'h0, 32'h0, 1'b0, 16'h0);
        resetMachine = 1'b0;

        // Sequential fetch
        stepCycle();
        checkState("seq1", 32'h4, ADDI_WORD, 32'h4, 1'b1, 16'h0);
        check("seq1.opcode", 32'(opCodeDecode), 32'(6'b001000));
        stepCycle();
        checkState("seq2", 32'h8, ADDI_WORD, 32'h8, 1'b1, 16'h0);

        // Stall three cycles at PC=8
        stallFetch = 1'b1;
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkState("stall", 32'h8, ADDI_WORD, 32'h8, 1'b1, 16'h0);
        end
        stallFetch = 1'b0;
        stepCycle();
        checkState("release", 32'hC, ADDI_WORD, 32'hC, 1'b1, 16'h0);

        // Branch to 0x1000_000C to set up the jump context
        branchTaken  = 1'b1;
        branchTarget = 32'h1000_000C;
        stepCycle();
        checkState("branch", 32'h1000_000C, 32'h0, 32'h0, 1'b0, 16'h1);
        branchTaken     = 1'b0;
        instructionData = JUMP_WORD;
        stepCycle();
        checkState("jload", 32'h1000_0010, JUMP_WORD, 32'h1000_0010, 1'b1, 16'h1);
        check("jload.opcode", 32'(opCodeDecode), 32'(6'b000010));

        // Jump under stall is ignored and stays in IF/ID
        jumpTaken  = 1'b1;
        stallFetch = 1'b1;
        stepCycle();
        checkState("jstall", 32'h1000_0010, JUMP_WORD, 32'h1000_0010, 1'b1, 16'h1);

        // Jump redirects on first unstalled cycle
        stallFetch = 1'b0;
        stepCycle();
        checkState("jump", 32'h1000_0100, 32'h0, 32'h0, 1'b0, 16'h2);
        jumpTaken       = 1'b0;
        instructionData = ADDI_WORD;
        stepCycle();
        checkState("jtarget", 32'h1000_0104, ADDI_WORD, 32'h1000_0104, 1'b1, 16'h2);

        // Branch + jump + stall together: branch wins, low bits cleared
        branchTaken  = 1'b1;
        branchTarget = 32'h0000_0203;
        jumpTaken    = 1'b1;
        stallFetch   = 1'b1;
        stepCycle();
        checkState("bjs", 32'h0000_0200, 32'h0, 32'h0, 1'b0, 16'h3);
        branchTaken = 1'b0;
        jumpTaken   = 1'b0;
        stallFetch  = 1'b0;
        stepCycle();
        checkState("btarget", 32'h0000_0204, ADDI_WORD, 32'h0000_0204, 1'b1, 16'h3);

        // PC wrap from 0xFFFF_FFFC
        branchTaken  = 1'b1;
        branchTarget = 32'hFFFF_FFFC;
        stepCycle();
        checkState("wrapbr", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 16'h4);
        branchTaken = 1'b0;
        stepCycle();
        checkState("wrap", 32'h0, ADDI_WORD, 32'h0, 1'b1, 16'h4);

        // Drive the flush counter to saturation with back-to-back branches
        branchTaken  = 1'b1;
        branchTarget = 32'h0000_0100;
        for (int i = 0; i < 65530; i++) begin
            stepCycle();
        end
        check("sat.pre", 32'(flushCount), 32'h0000_FFFE);
        stepCycle();
        check("sat.max", 32'(flushCount), 32'h0000_FFFF);
        stepCycle();
        check("sat.hold", 32'(flushCount), 32'h0000_FFFF);
        check("sat.pc", instructionAddress, 32'h0000_0100);
        branchTaken = 1'b0;

        // Reset during an active stall with a pending jump
        instructionData = JUMP_WORD;
        stepCycle();
        checkState("prerst", 32'h0000_0104, JUMP_WORD, 32'h0000_0104, 1'b1, 16'hFFFF);
        stallFetch   = 1'b1;
        jumpTaken    = 1'b1;
        resetMachine = 1'b1;
        stepCycle();
        checkState("rststall", 32'h0, 32'h0, 32'h0, 1'b0, 16'h0);
        resetMachine    = 1'b0;
        stallFetch      = 1'b0;
        jumpTaken       = 1'b0;
        instructionData = ADDI_WORD;
        stepCycle();
        checkState("postrst", 32'h4, ADDI_WORD, 32'h4, 1'b1, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Fetch stage of the five-stage MIPS pipeline, directly upstream of the instruction decoder. It holds the program counter, drives the instruction-memory address, and captures the fetched word and PC+4 into the IF/ID pipeline register. Decode reads the opcode from that register. The block applies stall, branch and jump redirects with the required bubble insertion, and keeps a saturating count of flushed fetches for debug.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of PC and instruction address
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- FLUSH_COUNT_WIDTH, 16, width of the flush counter

Ports:
- clockMachine, input, 1, single clock; all state updates on the rising edge
- resetMachine, input, 1, synchronous, active-high reset
- stallFetch, input, 1, from hazard unit; hold PC and IF/ID
- branchTaken, input, 1, resolved branch from EX stage (decoder branch enable AND ALU zero)
- branchTarget, input, ADDR_WIDTH, branch destination, valid with branchTaken
- jumpTaken, input, 1, decoder jump enable for the instruction currently in IF/ID
- instructionAddress, output, ADDR_WIDTH, instruction-memory read address; equals PC
- instructionData, input, 32, combinational instruction-memory read data for instructionAddress
- instructionDecode, output, 32, IF/ID instruction
- opCodeDecode, output, 6, instructionDecode[31:26], fed to the decoder
- pcPlusFourDecode, output, ADDR_WIDTH, IF/ID PC+4
- validDecode, output, 1, IF/ID holds a real instruction (0 = bubble)
- flushCount, output, FLUSH_COUNT_WIDTH, number of fetches discarded by redirects; saturates

## Operation
- Next-state priority: reset > branch > jump > stall > sequential.
- Reset: PC = RESET_PC; instructionDecode = 32'h0000_0000 (NOP); pcPlusFourDecode = 0; validDecode = 0; flushCount = 0.
- Sequential: PC <= PC+4. IF/ID <= {instructionData, PC+4, valid=1}.
- Branch (branchTaken=1): PC <= branchTarget. IF/ID <= NOP with valid=0. This action is taken even when stallFetch=1.
- Jump (jumpTaken=1, branchTaken=0, stallFetch=0):
  - PC <= {pcPlusFourDecode[31:28], instructionDecode[25:0], 2'b00}.
  - IF/ID <= NOP with valid=0.
- Jump under stall: when jumpTaken=1 and stallFetch=1, the jump is ignored. The jump instruction stays in IF/ID and redirects on the first unstalled cycle.
- Simultaneous branch and jump: the branch wins (it is the older instruction) and the jump is discarded.
- Stall: PC, IF/ID and flushCount hold.
- flushCount increments by 1 on every branch or jump redirect. It holds at the all-ones value, with no wrap.
- PC arithmetic is modulo 2^ADDR_WIDTH: 32'hFFFF_FFFC + 4 wraps to 0. PC bits [1:0] are always 0. branchTarget[1:0] is ignored and forced to 0.
- Reset asserted mid-stall or mid-redirect overrides everything on that edge.

## Timing
- instructionAddress is combinational from the PC register, with zero latency.
- IF/ID outputs are registered: an instruction at PC fetched in cycle n appears on instructionDecode in cycle n+1.
- Redirects:
  - Branch or jump observed in cycle n: the target is fetched in cycle n+1 and appears in IF/ID in cycle n+2.
  - Exactly one fetch-side bubble is produced per redirect.
- After reset deasserts at edge k, RESET_PC is fetched in the following cycle. validDecode first rises one cycle later.
- There are no combinational paths from stallFetch, branchTaken or jumpTaken to any output.

## Structure
- Shared pipeline package contains:
  - NOP_INSTRUCTION constant (32'h0)
  - opcode field positions [31:26] and jump-index field [25:0]
  - default RESET_PC
  - an IF/ID struct type {instruction, pcPlusFour, valid}
- Natural sub-module: if_id_register, the IF/ID register with load/hold/flush controls, reused later as the template for ID/EX.
- PC register, next-PC mux and flush counter live in the top level.

## Test plan
- Reset then run 4 cycles with instructionData = {6'b001000, 26'h0}: instructionAddress is 0, 4, 8, 12; validDecode goes 0 then 1; pcPlusFourDecode is 4, 8, 12; opCodeDecode = 6'b001000.
- Hold stallFetch for 3 cycles at PC=8: instructionAddress stays 8 and IF/ID is unchanged. After release, PC advances to 12.
- Put jump {6'b000010, 26'h0000040} in IF/ID with pcPlusFourDecode=32'h1000_0010 and assert jumpTaken:
  - next cycle PC = 32'h1000_0100 and validDecode = 0;
  - flushCount = 1.
- Assert branchTaken with branchTarget=32'h0000_0203 and jumpTaken in the same cycle, with stallFetch=1: PC = 32'h0000_0200 (branch wins, stall overridden, low bits cleared), and IF/ID becomes a bubble.
- Force flushCount to all-ones via 2^16 redirects, then one more redirect: the count stays 16'hFFFF. A PC at 32'hFFFF_FFFC wraps to 0.
- Assert reset during an active stall and pending jump: on the next edge PC = RESET_PC, validDecode = 0, flushCount = 0.
